sim_host_port: RTL and testbench

// - Synthesisable simulation host channel: CPU-side byte writes feed NUM_CHANNELS console FIFOs, an exit-code register and a watchdog.
// - Successor to the single-strobe console/exit GPIO scheme: multi-channel, buffered with back-pressure on the host drain.
// - Adds flush-before-exit ordering and a cycle-count timeout.
// - Sits between the CPU peripheral bus and the simulation top / host bridge; a testbench prints bytes and ends the run on exit_valid/timeout.

---
 rtl/sim_host_pkg.sv | 31 +++
 rtl/sim_host_fifo.sv | 49 ++++
 rtl/sim_host_port.sv | 193 +++++++++++++++++++
 tb/tb_sim_host_port.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_host_pkg.sv
// Shared types, address map helpers and width utilities for the simulation host port.
package sim_host_pkg;

    typedef logic [7:0] byte_t;

    // Exit-request state: idle, waiting for all consoles to drain, finished.
    typedef enum logic [1:0] {
        EXIT_IDLE    = 2'd0,
        EXIT_PENDING = 2'd1,
        EXIT_DONE    = 2'd2
    } exit_state_t;

    // Channel data addresses start at zero.
    localparam int CHAN_BASE = 0;

    // Exit-code register sits directly above the channel addresses.
    function automatic int exit_ofs(input int num_channels);
        return CHAN_BASE + num_channels;
    endfunction

    // Watchdog kick sits directly above the exit-code register.
    function automatic int kick_ofs(input int num_channels);
        return CHAN_BASE + num_channels + 1;
    endfunction

    // $clog2 that never yields a zero-width vector.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sim_host_fifo.sv
// Per-channel byte FIFO with wrap-bit pointers; push ignored when full, pop ignored when empty.
module sim_host_fifo
    import sim_host_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic  clk,
    input  logic  n_rst,
    input  logic  push,
    input  byte_t push_data,
    input  logic  pop,
    output byte_t head,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    byte_t       mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer update; pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/sim_host_port.sv
// Simulation host channel: console FIFOs with round-robin drain, exit register with flush ordering, watchdog.
module sim_host_port
    import sim_host_pkg::*;
#(
    parameter int NUM_CHANNELS   = 2,
    parameter int FIFO_DEPTH     = 16,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               wr_en,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [7:0]                         wr_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [clog2_min1(NUM_CHANNELS)-1:0] out_chan,
    output logic [7:0]                         out_data,
    output logic [NUM_CHANNELS-1:0]            overflow,
    output logic                               exit_valid,
    output logic [7:0]                         exit_code,
    output logic                               timeout
);

    localparam int                CW        = clog2_min1(NUM_CHANNELS);
    localparam logic [ADDR_W-1:0] EXIT_ADDR = ADDR_W'(exit_ofs(NUM_CHANNELS));
    localparam logic [ADDR_W-1:0] KICK_ADDR = ADDR_W'(kick_ofs(NUM_CHANNELS));

    logic [NUM_CHANNELS-1:0] push;
    logic [NUM_CHANNELS-1:0] pop;
    logic [NUM_CHANNELS-1:0] drop;
    logic [NUM_CHANNELS-1:0] full;
    logic [NUM_CHANNELS-1:0] empty;
    byte_t                   head [NUM_CHANNELS];

    logic                    exit_hit;
    logic [CW-1:0]           last_q;
    logic [CW-1:0]           lock_chan_q;
    logic                    lock_q;
    logic [CW-1:0]           pick;
    logic [CW-1:0]           sel;
    logic                    xfer;
    exit_state_t             state_q;
    exit_state_t             state_d;
    byte_t                   code_q;

    assign exit_hit = wr_en && (wr_addr == EXIT_ADDR);

    // Address decode into per-channel push and drop-on-full strobes.
    always_comb begin
        push = '0;
        drop = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(CHAN_BASE + i))) begin
                push[i] = !full[i];
                drop[i] = full[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        sim_host_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .n_rst     (n_rst),
            .push      (push[g]),
            .push_data (wr_data),
            .pop       (pop[g]),
            .head      (head[g]),
            .full      (full[g]),
            .empty     (empty[g])
        );
    end

    // Round-robin candidate: first non-empty channel after the last one that transferred.
    always_comb begin
        int unsigned idx;
        logic        found;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
            idx = int'(last_q) + i;
            if (idx >= NUM_CHANNELS) begin
                idx = idx - NUM_CHANNELS;
            end
            if (!found && !empty[idx]) begin
                pick  = CW'(idx);
                found = 1'b1;
            end
        end
    end

    // A stalled offer keeps its channel so out_chan/out_data stay put until taken.
    assign sel       = lock_q ? lock_chan_q : pick;
    assign out_chan  = sel;
    assign out_valid = !empty[sel];
    assign out_data  = out_valid ? head[sel] : '0;
    assign xfer      = out_valid && out_ready;

    // Route the handshake to the granted FIFO only.
    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (xfer && (sel == CW'(i))) begin
                pop[i] = 1'b1;
            end
        end
    end

    // Arbiter state; reset points last_q at the top channel so channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            last_q      <= CW'(NUM_CHANNELS - 1);
            lock_q      <= 1'b0;
            lock_chan_q <= '0;
        end else begin
            lock_q      <= out_valid && !out_ready;
            lock_chan_q <= sel;
            if (xfer) begin
                last_q <= sel;
            end
        end
    end

    // Sticky per-channel overflow flags.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            overflow <= '0;
        end else begin
            overflow <= overflow | drop;
        end
    end

    // Exit FSM state register and first-exit-code latch.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= EXIT_IDLE;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == EXIT_IDLE) && exit_hit) begin
                code_q <= wr_data;
            end
        end
    end

    // Exit next state: finish only once every FIFO is empty and no byte is entering.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EXIT_IDLE:    if (exit_hit) state_d = EXIT_PENDING;
            EXIT_PENDING: if ((&empty) && !(|push)) state_d = EXIT_DONE;
            EXIT_DONE:    state_d = EXIT_DONE;
            default:      state_d = EXIT_IDLE;
        endcase
    end

    assign exit_valid = (state_q == EXIT_DONE);
    assign exit_code  = code_q;

    if (TIMEOUT_CYCLES > 0) begin : g_wdog
        localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES + 1);

        logic             mapped;
        logic [CNT_W-1:0] cnt_q;
        logic             tmo_q;

        assign mapped  = wr_en && (wr_addr <= KICK_ADDR);
        assign timeout = tmo_q;

        // Idle-cycle counter; frozen once the run has ended either way.
        always_ff @(posedge clk) begin
            if (!n_rst) begin
                cnt_q <= '0;
                tmo_q <= 1'b0;
            end else if (!exit_valid && !tmo_q) begin
                if (mapped) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    if ((cnt_q + 1'b1) == CNT_W'(TIMEOUT_CYCLES)) begin
                        tmo_q <= 1'b1;
                    end
                end
            end
        end
    end else begin : g_no_wdog
        assign timeout = 1'b0;
    end

endmodule

// File: tb/tb_sim_host_port.sv
// Directed bench for sim_host_port: two instances share stimulus, one with a 100-cycle watchdog, one disabled.
module tb_sim_host_port;

    logic       clk;
    logic       n_rst;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       out_ready;

    logic       out_valid;
    logic [0:0] out_chan;
    logic [7:0] out_data;
    logic [1:0] overflow;
    logic       exit_valid;
    logic [7:0] exit_code;
    logic       timeout;

    logic       out_valid_nw;
    logic [0:0] out_chan_nw;
    logic [7:0] out_data_nw;
    logic [1:0] overflow_nw;
    logic       exit_valid_nw;
    logic [7:0] exit_code_nw;
    logic       timeout_nw;

    int n_vec = 0;
    int n_err = 0;

    sim_host_port #(
        .NUM_CHANNELS   (2),
        .FIFO_DEPTH     (4),
        .ADDR_W         (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_chan   (out_chan),
        .out_data   (out_data),
        .overflow   (overflow),
        .exit_valid (exit_valid),
        .exit_code  (exit_code),
        .timeout    (timeout)
    );

    sim_host_port #(
        .NUM_CHANNELS   (2),
        .FIFO_DEPTH     (4),
        .ADDR_W         (4),
        .TIMEOUT_CYCLES (0)
    ) dut_nw (
        .clk        (clk),
        .n_rst      (n_rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .out_valid  (out_valid_nw),
        .out_ready  (out_ready),
        .out_chan   (out_chan_nw),
        .out_data   (out_data_nw),
        .overflow   (overflow_nw),
        .exit_valid (exit_valid_nw),
        .exit_code  (exit_code_nw),
        .timeout    (timeout_nw)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit got=running exp=finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; callers then drive and sample.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic do_reset();
        n_rst     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        out_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_chan", 32'(out_chan), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_exit", 32'(exit_valid), 32'd0);
        check("rst_code", 32'(exit_code), 32'd0);
        check("rst_tmo", 32'(timeout), 32'd0);

        // 'H','i' on ch0, each visible one cycle after its write
        out_ready = 1'b1;
        wr(4'd0, 8'h48);
        check("hi_pre_valid", 32'(out_valid), 32'd0);
        step();
        wr(4'd0, 8'h69);
        check("hi_h_valid", 32'(out_valid), 32'd1);
        check("hi_h_data", 32'(out_data), 32'h48);
        check("hi_h_chan", 32'(out_chan), 32'd0);
        step();
        wr_en = 1'b0;
        check("hi_i_valid", 32'(out_valid), 32'd1);
        check("hi_i_data", 32'(out_data), 32'h69);
        check("hi_i_chan", 32'(out_chan), 32'd0);
        step();
        check("hi_empty", 32'(out_valid), 32'd0);

        // Overflow on ch1: fifth byte dropped
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            wr(4'd1, 8'(k));
            step();
        end
        wr_en = 1'b0;
        check("ovf_flag", 32'(overflow), 32'b10);
        check("ovf_chan", 32'(out_chan), 32'd1);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("ovf_drain_valid", 32'(out_valid), 32'd1);
            check("ovf_drain_data", 32'(out_data), 32'(k));
            check("ovf_drain_chan", 32'(out_chan), 32'd1);
            step();
        end
        check("ovf_drained", 32'(out_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'b10);

        // Round-robin A,x,B,y with a stall on B
        do_reset();
        wr(4'd0, 8'h41); step();
        wr(4'd1, 8'h78); step();
        wr(4'd0, 8'h42); step();
        wr(4'd1, 8'h79); step();
        wr_en     = 1'b0;
        out_ready = 1'b1;
        check("rr_a_data", 32'(out_data), 32'h41);
        check("rr_a_chan", 32'(out_chan), 32'd0);
        step();
        check("rr_x_data", 32'(out_data), 32'h78);
        check("rr_x_chan", 32'(out_chan), 32'd1);
        step();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check("rr_stall_data", 32'(out_data), 32'h42);
            check("rr_stall_chan", 32'(out_chan), 32'd0);
            step();
        end
        out_ready = 1'b1;
        check("rr_b_data", 32'(out_data), 32'h42);
        check("rr_b_chan", 32'(out_chan), 32'd0);
        step();
        check("rr_y_data", 32'(out_data), 32'h79);
        check("rr_y_chan", 32'(out_chan), 32'd1);
        step();
        check("rr_done", 32'(out_valid), 32'd0);

        // Flush-before-exit
        do_reset();
        wr(4'd0, 8'h01); step();
        wr(4'd0, 8'h02); step();
        wr(4'd0, 8'h03); step();
        wr(4'd2, 8'h2A); step();
        wr_en = 1'b0;
        check("fx_hold0", 32'(exit_valid), 32'd0);
        step();
        check("fx_hold1", 32'(exit_valid), 32'd0);
        check("fx_code_latched", 32'(exit_code), 32'h2A);
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            check("fx_drain_data", 32'(out_data), 32'(k));
            check("fx_not_yet", 32'(exit_valid), 32'd0);
            step();
        end
        step();
        check("fx_exit_valid", 32'(exit_valid), 32'd1);
        check("fx_exit_code", 32'(exit_code), 32'h2A);
        wr(4'd2, 8'h07);
        step();
        wr_en = 1'b0;
        check("fx_second_code", 32'(exit_code), 32'h2A);
        check("fx_exit_sticky", 32'(exit_valid), 32'd1);

        // Watchdog: kick sampled on edge K, timeout on edge K+100
        do_reset();
        step();
        wr(4'd3, 8'h00);
        step();
        wr_en = 1'b0;
        for (int j = 1; j <= 103; j++) begin
            step();
            if (j == 99) begin
                check("wd_before", 32'(timeout), 32'd0);
            end
            if (j == 100) begin
                check("wd_fire", 32'(timeout), 32'd1);
                check("wd_disabled", 32'(timeout_nw), 32'd0);
            end
        end
        check("wd_sticky", 32'(timeout), 32'd1);
        check("wd_disabled_late", 32'(timeout_nw), 32'd0);

        // Mid-operation reset discards bytes, flags and pending exit
        do_reset();
        for (int k = 0; k < 5; k++) begin
            wr(4'd0, 8'(8'h10 + k));
            step();
        end
        wr(4'd2, 8'h55);
        step();
        wr_en = 1'b0;
        check("mr_pre_ovf", 32'(overflow), 32'b01);
        check("mr_pre_valid", 32'(out_valid), 32'd1);
        check("mr_pre_code", 32'(exit_code), 32'h55);
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_ovf", 32'(overflow), 32'd0);
        check("mr_exit", 32'(exit_valid), 32'd0);
        check("mr_code", 32'(exit_code), 32'd0);
        check("mr_data", 32'(out_data), 32'd0);
        step();
        step();
        check("mr_still_empty", 32'(out_valid), 32'd0);
        check("mr_no_exit", 32'(exit_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
